// File: rtl/uart_tx_sched.sv
// Round-robin scheduler funnelling four byte requesters into one Wishbone UART slave.
// IDLE accepts in 0 cycles; a write holds stb until ack/err/timeout; each byte is followed by a BYTE_CLKS gap.
module uart_tx_sched #(
  parameter int DAT_WIDTH   = 64,
  parameter int BYTE_CLKS   = 8680,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [3:0]           req_valid_i,
  input  logic [31:0]          req_data_i,
  output logic [3:0]           req_ready_o,
  output logic                 uart_stb_o,
  output logic                 uart_we_o,
  output logic [DAT_WIDTH-1:0] uart_dat_o,
  input  logic                 uart_ack_i,
  input  logic                 uart_err_i,
  output logic [1:0]           grant_o,
  output logic                 busy_o,
  output logic [7:0]           err_cnt_o
);

  localparam int GAP_W = ($clog2(BYTE_CLKS + 1) > 32) ? $clog2(BYTE_CLKS + 1) : 32;
  localparam int TMO_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         grant_q, grant_d;
  logic [7:0]         byte_q, byte_d;
  logic [7:0]         err_q, err_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic [3:0]         win;
  logic [1:0]         win_idx;
  logic [1:0]         rr_idx;
  logic               found;
  logic               accept;

  // Search starts just after the last accepted requester and wraps.
  always_comb begin
    win     = '0;
    win_idx = '0;
    rr_idx  = '0;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = last_q + 2'(i);
      if (!found && req_valid_i[rr_idx]) begin
        win[rr_idx] = 1'b1;
        win_idx     = rr_idx;
        found       = 1'b1;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE && !rst_i) ? win : 4'b0000;
  assign accept      = |(req_valid_i & req_ready_o);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    byte_d  = byte_q;
    err_d   = err_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          byte_d  = req_data_i[{win_idx, 3'b000} +: 8];
          grant_d = win_idx;
          last_d  = win_idx;
          tmo_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        tmo_d = tmo_q + 1'b1;
        // An error beats a simultaneous ack; a silent slave is treated as an error.
        if (uart_err_i || (!uart_ack_i && tmo_q == TMO_W'(ACK_TIMEOUT - 1))) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          gap_d   = '0;
          state_d = GAP;
        end else if (uart_ack_i) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_W'(BYTE_CLKS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      grant_q <= 2'd0;
      byte_q  <= 8'd0;
      err_q   <= 8'd0;
      gap_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
  end

  assign uart_stb_o = (state_q == WRITE);
  assign uart_we_o  = (state_q == WRITE);
  assign uart_dat_o = (state_q == WRITE) ? DAT_WIDTH'(byte_q) : '0;
  assign grant_o    = grant_q;
  assign busy_o     = !rst_i && (state_q != IDLE);
  assign err_cnt_o  = err_q;

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 64: width of the Wishbone data bus.
REQ-002 SHALL have parameter BYTE_CLKS, default 8680: clk_i cycles reserved per UART byte (10 bits x 868).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16: maximum clk_i cycles stb is held waiting for ack/err.
REQ-004 SHALL have clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have req_valid_i, input, 4: per-requester byte valid.
REQ-007 SHALL have req_data_i, input, 32: packed bytes; requester n on bits [8n+7:8n].
REQ-008 SHALL have req_ready_o, output, 4: per-requester accept, at most one bit high.
REQ-009 SHALL have uart_stb_o, output, 1: Wishbone strobe to the UART slave.
REQ-010 SHALL have uart_we_o, output, 1: Wishbone write enable.
REQ-011 SHALL have uart_dat_o, output, DAT_WIDTH: write data.
REQ-012 SHALL have uart_ack_i, input, 1: Wishbone acknowledge.
REQ-013 SHALL have uart_err_i, input, 1: Wishbone error.
REQ-014 SHALL have grant_o, output, 2: index of the requester currently owning the UART.
REQ-015 SHALL have busy_o, output, 1: high in every state except IDLE.
REQ-016 SHALL have err_cnt_o, output, 8: saturating count of failed writes.

Function
REQ-017 SHALL implement an FSM with three states: IDLE, WRITE, GAP.
REQ-018 IDLE: req_ready_o SHALL be combinationally one-hot on the round-robin winner among asserted req_valid_i, and zero if none is valid; req_ready_o SHALL be zero in every other state.
REQ-019 Round-robin: search SHALL start at (last_grant+1) mod 4 and wrap; last_grant SHALL update only on an accepted transfer.
REQ-020 Transfer SHALL occur when req_valid_i[n] & req_ready_o[n]; on that edge latch the byte, set grant_o=n and go to WRITE.
REQ-021 WRITE: uart_stb_o=1, uart_we_o=1 and uart_dat_o={zeros, byte} SHALL hold from the first WRITE cycle until exit; all three SHALL be 0 outside WRITE.
REQ-022 WRITE exit on uart_ack_i=1 SHALL go to GAP.
REQ-023 WRITE exit on uart_err_i=1 SHALL go to GAP and increment err_cnt_o; err takes priority when ack and err are both high.
REQ-024 If neither ack nor err arrives within ACK_TIMEOUT cycles of stb, the FSM SHALL drop stb, increment err_cnt_o and go to GAP.
REQ-025 err_cnt_o SHALL saturate at 255 with no wrap.
REQ-026 GAP SHALL last exactly BYTE_CLKS cycles, then return to IDLE; IDLE acceptance SHALL be possible on the first IDLE cycle.
REQ-027 Minimum spacing between consecutive stb rising edges SHALL be BYTE_CLKS + 2 cycles, which prevents writes from being dropped while the UART is still transmitting.
REQ-028 req_valid_i changes outside IDLE SHALL have no effect; a requester SHALL NOT be starved, with a worst-case wait of 3 transfers.
REQ-029 grant_o SHALL hold its value through WRITE and GAP and keep its last value in IDLE.
REQ-030 Counter widths SHALL cover BYTE_CLKS and ACK_TIMEOUT without overflow, at a minimum of 32 and 8 bits respectively.

Reset
REQ-031 rst_i=1 at any clock edge SHALL force state IDLE, last_grant=3 (so requester 0 wins first), grant_o=0, err_cnt_o=0, all counters to 0, and uart_stb_o/uart_we_o/uart_dat_o=0.
REQ-032 Reset asserted mid-WRITE SHALL drop stb on the next edge; the latched byte SHALL be discarded.
REQ-033 While rst_i=1: req_ready_o=0 and busy_o=0.

Verification
REQ-034 Single byte: after reset, valid[2]=1 with data 8'h41; slave acks 1 cycle after stb -> ready[2] pulses 1 cycle, stb lasts 2 cycles with dat_o=64'h41, grant_o=2, busy_o stays high for BYTE_CLKS+2 cycles.
REQ-035 Fairness: all four valid held high continuously -> grants in order 0,1,2,3,0 with stb edges spaced BYTE_CLKS+2 apart.
REQ-036 Timeout: slave never acks -> stb high for exactly ACK_TIMEOUT cycles, err_cnt_o=1, then GAP, then next grant.
REQ-037 Error priority: ack and err asserted in the same cycle -> err_cnt_o increments and the FSM enters GAP.
REQ-038 Saturation: 260 errored writes -> err_cnt_o=255.
REQ-039 Reset mid-WRITE: rst_i pulsed on the 1st WRITE cycle -> stb=0 next cycle, grant_o=0, err_cnt_o=0, and the next accepted requester is 0 when valid.
